// File: rtl/switch_rd_sched.sv
// Output-side read scheduler: weighted round-robin over four queue controllers with
// per-port credits and SLOT_LEN pacing. Optional grant counters under SWITCH_RD_SCHED_STATS_EN.
module switch_rd_sched #(
  parameter int unsigned SLOT_LEN = 6,
  parameter int unsigned CW       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      ptr_rdy,
  input  logic [3:0]      o_cell_bp,
  input  logic [4*CW-1:0] cfg_weight,
`ifdef SWITCH_RD_SCHED_STATS_EN
  input  logic            stats_clr,
  output logic [63:0]     grant_cnt,
`endif
  output logic [3:0]      ptr_ack,
  output logic [3:0]      sel,
  output logic            slot_start,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ARB, SLOT} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] credit    [4];
  logic [CW-1:0] credit_nx [4];
  logic [CW-1:0] eff_credit[4];
  logic [1:0]    rot, rot_nx;
  logic [3:0]    cnt, cnt_nx;
  logic [3:0]    ptr_ack_nx, sel_nx;
  logic          slot_start_nx;
  logic [3:0]    elig, cand;
  logic [1:0]    win, idx;
  logic          found;

  assign elig = ptr_rdy & ~o_cell_bp;
  assign busy = (state == ARB) || (state == SLOT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rot        <= '0;
      cnt        <= '0;
      ptr_ack    <= '0;
      sel        <= '0;
      slot_start <= 1'b0;
      for (int unsigned n = 0; n < 4; n++) credit[n] <= '0;
    end else begin
      state      <= state_nx;
      rot        <= rot_nx;
      cnt        <= cnt_nx;
      ptr_ack    <= ptr_ack_nx;
      sel        <= sel_nx;
      slot_start <= slot_start_nx;
      for (int unsigned n = 0; n < 4; n++) credit[n] <= credit_nx[n];
    end
  end

  always_comb begin
    state_nx      = state;
    rot_nx        = rot;
    cnt_nx        = cnt;
    ptr_ack_nx    = '0;
    sel_nx        = sel;
    slot_start_nx = 1'b0;
    cand          = '0;
    win           = '0;
    idx           = '0;
    found         = 1'b0;
    for (int unsigned n = 0; n < 4; n++) begin
      credit_nx[n]  = credit[n];
      eff_credit[n] = credit[n];
    end

    case (state)
      IDLE: if (elig != '0) state_nx = ARB;

      ARB: begin
        if (elig == '0) begin
          state_nx = IDLE;
        end else begin
          for (int unsigned n = 0; n < 4; n++)
            cand[n] = elig[n] & (credit[n] != '0);
          // Global reload when no eligible port holds credit; arbitrate on the reloaded values.
          if (cand == '0) begin
            for (int unsigned n = 0; n < 4; n++)
              eff_credit[n] = (cfg_weight[n*CW +: CW] == '0) ? CW'(1) : cfg_weight[n*CW +: CW];
            cand = elig;
          end
          for (int unsigned i = 0; i < 4; i++) begin
            idx = rot + 2'(i);
            if (!found && cand[idx]) begin
              win   = idx;
              found = 1'b1;
            end
          end
          for (int unsigned n = 0; n < 4; n++) credit_nx[n] = eff_credit[n];
          if (eff_credit[win] != '0) credit_nx[win] = eff_credit[win] - CW'(1);
          ptr_ack_nx    = 4'b0001 << win;
          sel_nx        = 4'b0001 << win;
          slot_start_nx = 1'b1;
          rot_nx        = win + 2'd1;
          cnt_nx        = '0;
          state_nx      = SLOT;
        end
      end

      SLOT: begin
        // Leave when the incremented count reaches SLOT_LEN-2, so IDLE+ARB close the slot on time.
        cnt_nx = cnt + 4'd1;
        if (cnt == 4'(SLOT_LEN - 3)) state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

`ifdef SWITCH_RD_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
    end else if (stats_clr) begin
      grant_cnt <= '0;
    end else begin
      for (int unsigned n = 0; n < 4; n++)
        if (ptr_ack[n]) grant_cnt[16*n +: 16] <= grant_cnt[16*n +: 16] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_switch_rd_sched.sv
// Scoreboard bench for switch_rd_sched: expected grants queued at stimulus time,
// popped and compared as each ptr_ack pulse appears.
module tb_switch_rd_sched;

  localparam int SLOT_LEN = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ptr_rdy = '0;
  logic [3:0]  o_cell_bp = '0;
  logic [15:0] cfg_weight = 16'h1111;
  logic [3:0]  ptr_ack, sel;
  logic        slot_start, busy;
`ifdef SWITCH_RD_SCHED_STATS_EN
  logic        stats_clr = 1'b0;
  logic [63:0] grant_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [3:0] exp_q[$];

  switch_rd_sched #(.SLOT_LEN(SLOT_LEN), .CW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ptr_rdy    (ptr_rdy),
    .o_cell_bp  (o_cell_bp),
    .cfg_weight (cfg_weight),
`ifdef SWITCH_RD_SCHED_STATS_EN
    .stats_clr  (stats_clr),
    .grant_cnt  (grant_cnt),
`endif
    .ptr_ack    (ptr_ack),
    .sel        (sel),
    .slot_start (slot_start),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Structural invariants every cycle.
  always @(negedge clk) begin
    check("ack_onehot", 64'($countones(ptr_ack) <= 1), 64'd1);
    check("sel_onehot", 64'($countones(sel) <= 1), 64'd1);
    check("start_with_ack", 64'(slot_start), 64'(ptr_ack != '0));
  end

  task automatic wait_ack(input int bound, output logic [3:0] got, output int c);
    got = '0;
    c   = cyc;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (ptr_ack != '0) begin
        got = ptr_ack;
        c   = cyc;
        break;
      end
    end
  endtask

  // Pops n expected grants; first_gap>0 also checks latency from start.
  task automatic run_grants(input int n, input string tag, input int start, input int first_gap);
    logic [3:0] got, expv;
    int c, prev;
    prev = start;
    for (int i = 0; i < n; i++) begin
      wait_ack(SLOT_LEN + 6, got, c);
      expv = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
      check({tag, "_ack"}, 64'(got), 64'(expv));
      check({tag, "_sel"}, 64'(sel), 64'(expv));
      if (i == 0 && first_gap > 0) check({tag, "_latency"}, 64'(c - start), 64'(first_gap));
      else if (i > 0) check({tag, "_spacing"}, 64'(c - prev), 64'(SLOT_LEN));
      prev = c;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ptr_rdy = '0;
    o_cell_bp = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] got;
    int c, c0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ack", 64'(ptr_ack), 64'h0);
    check("rst_sel", 64'(sel), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'h0);

    // Single port, weights 1
    cfg_weight = 16'h1111;
    ptr_rdy = 4'b0001;
    c0 = cyc;
    repeat (5) exp_q.push_back(4'b0001);
    run_grants(5, "single", c0, 2);
    ptr_rdy = '0;
    repeat (10) @(negedge clk);
    check("single_sel_hold", 64'(sel), 64'h1);
    check("single_idle_busy", 64'(busy), 64'h0);
    check("single_idle_ack", 64'(ptr_ack), 64'h0);

    // All ports, equal weights: plain round-robin
    do_reset();
    cfg_weight = 16'h1111;
    ptr_rdy = 4'b1111;
    c0 = cyc;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 4; p++) exp_q.push_back(4'b0001 << p);
    run_grants(8, "rr", c0, 2);

    // Port 0 weight 3
    do_reset();
    cfg_weight = 16'h1113;
    ptr_rdy = 4'b1111;
    c0 = cyc;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0001); exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010); exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0001); exp_q.push_back(4'b0001);
    run_grants(12, "wrr", c0, 2);

    // Backpressure on port 0
    do_reset();
    cfg_weight = 16'h1111;
    ptr_rdy = 4'b0011;
    o_cell_bp = 4'b0001;
    c0 = cyc;
    repeat (3) exp_q.push_back(4'b0010);
    run_grants(3, "bp", c0, 2);
    o_cell_bp = '0;
    c0 = cyc;
    exp_q.push_back(4'b0001);
    run_grants(1, "bp_release", c0, SLOT_LEN);
    o_cell_bp = 4'b0011;
    @(negedge clk);
    check("bp_slot_ack", 64'(ptr_ack), 64'h0);
    check("bp_slot_sel", 64'(sel), 64'h1);
    check("bp_slot_busy", 64'(busy), 64'h1);
    wait_ack(20, got, c);
    check("bp_no_grant", 64'(got), 64'h0);
    check("bp_sel_hold", 64'(sel), 64'h1);
    check("bp_idle_busy", 64'(busy), 64'h0);

    // Reset mid-slot
    do_reset();
    cfg_weight = 16'h1111;
    ptr_rdy = 4'b1111;
    c0 = cyc;
    exp_q.push_back(4'b0001);
    run_grants(1, "pre_rst", c0, 2);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ack", 64'(ptr_ack), 64'h0);
    check("midrst_sel", 64'(sel), 64'h0);
    check("midrst_start", 64'(slot_start), 64'h0);
    check("midrst_busy", 64'(busy), 64'h0);
    @(negedge clk);
    check("midrst_ack_hold", 64'(ptr_ack), 64'h0);
    rst = 1'b0;
    ptr_rdy = 4'b0100;
    c0 = cyc;
    exp_q.push_back(4'b0100);
    run_grants(1, "post_rst", c0, 2);

`ifdef SWITCH_RD_SCHED_STATS_EN
    do_reset();
    check("stats_rst", grant_cnt, 64'h0);
    cfg_weight = 16'h1111;
    ptr_rdy = 4'b1111;
    c0 = cyc;
    for (int i = 0; i < 10; i++) exp_q.push_back(4'b0001 << (i % 4));
    run_grants(10, "stats", c0, 2);
    ptr_rdy = '0;
    repeat (10) @(negedge clk);
    check("stats_cnt", grant_cnt, {16'd2, 16'd2, 16'd3, 16'd3});
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    @(negedge clk);
    check("stats_clr", grant_cnt, 64'h0);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
